// File: rtl/simon_engine.sv
// Simon memory game: LFSR-generated colour sequence, timed lamp playback,
// and checking of the player's presses with an optional per-press timeout.
module simon_engine #(
    parameter int N_COLOURS      = 4,
    parameter int MAX_LEN        = 16,
    parameter int SHOW_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int CW = $clog2(N_COLOURS),
    localparam int RW = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           seed,
    input  logic [N_COLOURS-1:0] btn,
    output logic [N_COLOURS-1:0] led,
    output logic [2:0]           state,
    output logic [RW-1:0]        round,
    output logic                 win,
    output logic                 lose
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int PW = $clog2(GAP_CYCLES + SHOW_CYCLES);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GEN  = 3'd1,
        S_SHOW = 3'd2,
        S_WAIT = 3'd3,
        S_WIN  = 3'd4,
        S_LOSE = 3'd5
    } state_t;

    state_t              cur_q, nxt;
    logic [7:0]          lfsr_q, lfsr_d;
    logic [RW-1:0]       gen_q, gen_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [RW-1:0]       sidx_q, sidx_d;
    logic [RW-1:0]       idx_q, idx_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [RW-1:0]       round_q, round_d;
    logic [N_COLOURS-1:0] btn_prev_q;
    logic [N_COLOURS-1:0] led_q, led_d;
    logic                win_q, win_d, lose_q, lose_d;
    logic                mem_we;
    logic                press;
    logic [N_COLOURS-1:0] exp_oh;

    // Sequence memory is deliberately not reset; GEN rewrites every used entry.
    logic [CW-1:0] mem [0:(1<<AW)-1];

    function automatic logic [N_COLOURS-1:0] onehot(input logic [CW-1:0] c);
        onehot    = '0;
        onehot[c] = 1'b1;
    endfunction

    assign press  = (btn_prev_q == '0) && (btn != '0);
    assign exp_oh = onehot(mem[idx_q[AW-1:0]]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q      <= S_IDLE;
            lfsr_q     <= 8'h01;
            gen_q      <= '0;
            phase_q    <= '0;
            sidx_q     <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            round_q    <= '0;
            btn_prev_q <= '0;
        end else begin
            cur_q      <= nxt;
            lfsr_q     <= lfsr_d;
            gen_q      <= gen_d;
            phase_q    <= phase_d;
            sidx_q     <= sidx_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            round_q    <= round_d;
            btn_prev_q <= btn;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[gen_q[AW-1:0]] <= lfsr_q[CW-1:0];
    end

    always_comb begin
        nxt     = cur_q;
        lfsr_d  = lfsr_q;
        gen_d   = gen_q;
        phase_d = phase_q;
        sidx_d  = sidx_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        round_d = round_q;
        mem_we  = 1'b0;
        case (cur_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    nxt    = S_GEN;
                    lfsr_d = (seed == 8'h00) ? 8'h01 : seed;
                    gen_d  = '0;
                end
            end
            S_GEN: begin
                mem_we = 1'b1;
                lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                if (gen_q == RW'(MAX_LEN - 1)) begin
                    nxt     = S_SHOW;
                    round_d = RW'(1);
                    phase_d = '0;
                    sidx_d  = '0;
                end else begin
                    gen_d = gen_q + RW'(1);
                end
            end
            S_SHOW: begin
                if (phase_q == PW'(GAP_CYCLES + SHOW_CYCLES - 1)) begin
                    phase_d = '0;
                    if (sidx_q == round_q - RW'(1)) begin
                        nxt   = S_WAIT;
                        idx_d = '0;
                        tmo_d = '0;
                    end else begin
                        sidx_d = sidx_q + RW'(1);
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            S_WAIT: begin
                // A press in the expiry cycle wins over the timeout.
                if (press) begin
                    if (btn == exp_oh) begin
                        idx_d = idx_q + RW'(1);
                        tmo_d = '0;
                        if (idx_q + RW'(1) == round_q) begin
                            if (round_q < RW'(MAX_LEN)) begin
                                nxt     = S_SHOW;
                                round_d = round_q + RW'(1);
                                phase_d = '0;
                                sidx_d  = '0;
                            end else begin
                                nxt = S_WIN;
                            end
                        end
                    end else begin
                        nxt = S_LOSE;
                    end
                end else if (TIMEOUT_CYCLES > 0) begin
                    if (tmo_q == TW'(TIMEOUT_CYCLES)) nxt = S_LOSE;
                    else                              tmo_d = tmo_q + TW'(1);
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Outputs are computed from next-cycle values so the registers line up with state.
    always_comb begin
        led_d  = '0;
        win_d  = (nxt == S_WIN);
        lose_d = (nxt == S_LOSE);
        if (nxt == S_SHOW && phase_d >= PW'(GAP_CYCLES))
            led_d = onehot(mem[sidx_d[AW-1:0]]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q  <= '0;
            win_q  <= 1'b0;
            lose_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            win_q  <= win_d;
            lose_q <= lose_d;
        end
    end

    assign led   = led_q;
    assign state = cur_q;
    assign round = round_q;
    assign win   = win_q;
    assign lose  = lose_q;

endmodule

// File: doc/simon_engine.md
SIMON_ENGINE -- requirements
Module: simon_engine

Interface
REQ-001 Parameter N_COLOURS, default 4, number of colour channels; the legal values are 2, 4 and 8.
REQ-002 Parameter MAX_LEN, default 16, maximum sequence length and the winning round; the legal range is 1..32.
REQ-003 Parameter SHOW_CYCLES, default 4, number of cycles each colour is lit during playback; minimum 1.
REQ-004 Parameter GAP_CYCLES, default 2, number of dark cycles before each playback element; minimum 1.
REQ-005 Parameter TIMEOUT_CYCLES, default 1000, number of idle cycles allowed per player press; the value 0 disables the timeout.
REQ-006 Derived widths: CW = log2(N_COLOURS); RW = clog2(MAX_LEN+1).
REQ-007 Port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-008 Port rst, input, 1 bit, reset; asynchronous and active-high.
REQ-009 Port start, input, 1 bit, level-sensitive request to begin a game.
REQ-010 Port seed, input, 8 bits, LFSR seed; sampled only in the cycle a start is accepted.
REQ-011 Port btn, input, N_COLOURS bits, player buttons; active-high, one bit per colour.
REQ-012 Port led, output, N_COLOURS bits, one-hot playback lamps; registered.
REQ-013 Port state, output, 3 bits, current state code; registered.
REQ-014 Port round, output, RW bits, current round (sequence length being played); registered.
REQ-015 Port win, output, 1 bit, high while in WIN; registered.
REQ-016 Port lose, output, 1 bit, high while in LOSE; registered.

Function
REQ-017 State codes: IDLE=0, GEN=1, SHOW=2, WAIT=3, WIN=4, LOSE=5; codes 6 and 7 shall never occur.
REQ-018 Start acceptance: start=1 in IDLE, WIN or LOSE moves the FSM to GEN on the next edge; start is ignored in every other state.
REQ-019 Seed loading: on start acceptance the LFSR loads seed; a seed of 0x00 loads 0x01 instead.
REQ-020 LFSR definition: 8-bit Fibonacci; next = {q[6:0], q7^q5^q4^q3}.
REQ-021 GEN duration: GEN lasts exactly MAX_LEN cycles.
REQ-022 GEN per-cycle action: in GEN cycle k, entry mem[k] = q[CW-1:0] is written, then the LFSR advances.
REQ-023 GEN exit: after GEN, round=1 and the FSM enters SHOW.
REQ-024 SHOW element order: SHOW plays elements i = 0..round-1; each element is GAP_CYCLES with led=0, then SHOW_CYCLES with led = one-hot(mem[i]).
REQ-025 SHOW exit: the FSM enters WAIT on the edge after the final lit cycle of element round-1; led=0 in WAIT.
REQ-026 Press event: a btn_prev register samples btn every cycle in all states; a press event occurs when btn_prev==0 and btn!=0.
REQ-027 Held buttons: a button still held on entry to WAIT produces no press event until it is released.
REQ-028 Press handling: in WAIT, each press event is checked against mem[idx], where idx starts at 0 on WAIT entry.
REQ-029 Correct press: a one-hot btn equal to one-hot(mem[idx]) is correct and increments idx.
REQ-030 Wrong press: a mismatching press or a press with more than one bit set moves the FSM to LOSE on the next edge.
REQ-031 Round complete, not final: when a correct press makes idx==round and round<MAX_LEN, round increments and the FSM enters SHOW.
REQ-032 Round complete, final: when a correct press makes idx==round and round==MAX_LEN, the FSM enters WIN; round holds MAX_LEN.
REQ-033 Timeout: when TIMEOUT_CYCLES>0, a timeout counter clears on WAIT entry and on each correct press, and increments on every other WAIT cycle.
REQ-034 Timeout expiry: when the timeout counter reaches TIMEOUT_CYCLES with no press event in that cycle, the FSM enters LOSE.
REQ-035 Press/timeout priority: a press event in the same cycle as timeout expiry takes priority over the timeout.
REQ-036 Terminal states: WIN and LOSE hold until start is accepted; round holds its last value; led=0.
REQ-037 Restart: a restart from WIN or LOSE regenerates the whole sequence from the newly sampled seed.
REQ-038 Flag decoding: win = (state==WIN) and lose = (state==LOSE), both registered with the state.

Reset
REQ-039 Asserting rst at any time, including mid-GEN, mid-SHOW or mid-WAIT, immediately forces state=IDLE, led=0, round=0, win=0, lose=0, idx=0, btn_prev=0, all timers=0 and LFSR=0x01.
REQ-040 Sequence memory contents are not reset and are fully rewritten in GEN before any use.
REQ-041 After rst deasserts, no transition occurs until start is accepted.

Verification (N_COLOURS=4, MAX_LEN=4, SHOW_CYCLES=2, GAP_CYCLES=1, TIMEOUT_CYCLES=10)
REQ-042 Sequence generation and first playback: seed=0x01, start pulse -> GEN for 4 cycles with mem = 1,2,0,0; round=1; SHOW gives led=0000 for 1 cycle, then 0010 for 2 cycles; then state=3.
REQ-043 Full win: press 0010; then 0010,0100; then 0010,0100,0001; then 0010,0100,0001,0001, each press released between presses -> round steps 1->4, then state=4 and win=1.
REQ-044 Wrong press: in round 2, press 0010 then 1000 -> state=5 and lose=1 on the next edge; round stays 2.
REQ-045 Multi-press and held button: btn=0011 as one press -> LOSE; separately, btn held at 0010 through WAIT entry -> no press counted until released and pressed again.
REQ-046 Timeout: no press for 10 WAIT cycles -> LOSE; a correct press at cycle 9 -> counter clears and play continues.
REQ-047 Reset and restart: rst pulse mid-SHOW -> led=0 and state=0 immediately; start from LOSE with seed=0x00 -> behaves as seed 0x01 (mem = 1,2,0,0).
